// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg: datapath-wide constants and types shared by mult/div units  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

    // Booth recoding of {Q[0], Q_1}; 00 and 11 leave the accumulator alone
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mult_booth_step.sv
// +----------------------------------------------------------------------+
// | mult_booth_step: one radix-2 Booth step (add/sub then arith shift)   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_booth_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q1})
            BOOTH_ADD: w_sum = i_a + i_m;
            BOOTH_SUB: w_sum = i_a - i_m;
            default:   w_sum = i_a;
        endcase
    end

    // Shift {A,Q,Q_1} right by one, replicating the accumulator sign bit
    assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q1 = i_q[0];

endmodule

`default_nettype wire

// File: rtl/mult_booth.sv
// +----------------------------------------------------------------------+
// | mult_booth: sequential signed radix-2 Booth multiplier feeding Hi/Lo |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_booth
    import cpu_pkg::*;
#(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Multiplicando,
    input  logic [WIDTH-1:0] Multiplicador,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [CNT_W-1:0] c_STEPS = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    mult_state_t      r_state;
    mult_state_t      w_state_nxt;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_q1_nxt;
    logic             w_load;
    logic             w_last;

    // A start during RUN is dropped; FINISH accepts it for back-to-back use
    assign w_load = start && (r_state != RUN);
    assign w_last = (r_state == RUN) && (r_cnt == c_ONE);

    mult_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a  (r_a),
        .i_q  (r_q),
        .i_q1 (r_q1),
        .i_m  (r_m),
        .o_a  (w_a_nxt),
        .o_q  (w_q_nxt),
        .o_q1 (w_q1_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = w_last ? FINISH : RUN;
            FINISH:  w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == RUN);
        Done = (r_state == FINISH);
        Hi   = r_hi;
        Lo   = r_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_load) begin
            r_a   <= '0;
            r_m   <= {Multiplicando[WIDTH-1], Multiplicando};
            r_q   <= Multiplicador;
            r_q1  <= 1'b0;
            r_cnt <= c_STEPS;
        end else if (r_state == RUN) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= w_q1_nxt;
            r_cnt <= r_cnt - c_ONE;
            // Hi/Lo only ever see the final step's result
            if (w_last) begin
                r_hi <= w_a_nxt[WIDTH-1:0];
                r_lo <= w_q_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_booth.sv
// +----------------------------------------------------------------------+
// | tb_mult_booth: self-checking bench for the Booth multiplier          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_booth;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_booth #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .Multiplicando (mcand),
        .Multiplicador (mplier),
        .Busy          (busy),
        .Done          (done),
        .Hi            (hi),
        .Lo            (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_flags busy/done=%b expected 00", {busy, done}); end
        n_tests++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got %h expected 0", {hi, lo}); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if ({busy, done, hi, lo} !== 66'd0) begin n_fail++; $display("FAIL reset_idle got %h expected 0", {busy, done, hi, lo}); end
    endtask

    task automatic test_basic();
        int done_cnt = 0;
        int done_at  = -1;
        int busy_bad = 0;
        do_start(32'd3, 32'd5);
        n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL basic_busy_edge0 busy/done=%b expected 10", {busy, done}); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin done_cnt++; done_at = k; end
            if (busy !== (k < 32)) busy_bad++;
            if (k == 32) begin
                n_tests++; if ({hi, lo} !== 64'h0000_0000_0000_000F) begin n_fail++; $display("FAIL basic_3x5 got %h expected 000000000000000f", {hi, lo}); end
            end
        end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count got %0d expected 1", done_cnt); end
        n_tests++; if (done_at != 32) begin n_fail++; $display("FAIL basic_done_cycle got %0d expected 32", done_at); end
        n_tests++; if (busy_bad != 0) begin n_fail++; $display("FAIL basic_busy_window got %0d bad cycles expected 0", busy_bad); end
    endtask

    task automatic test_directed();
        logic [31:0] ta[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] tb[5] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
        logic [63:0] te[5] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 64'h40000000_00000000,
                               64'h3FFFFFFF_00000001, 64'hC0000000_80000000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_start(ta[i], tb[i]);
            wait_done(lat);
            n_tests++; if (lat != 32) begin n_fail++; $display("FAIL directed%0d_latency got %0d expected 32", i, lat); end
            n_tests++; if ({hi, lo} !== te[i]) begin n_fail++; $display("FAIL directed%0d_product got %h expected %h", i, {hi, lo}, te[i]); end
        end
    endtask

    task automatic test_start_ignored();
        int done_at = -1;
        do_start(32'd6, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) begin start = 1'b1; mcand = 32'd2; mplier = 32'd2; end
            if (k == 10) begin start = 1'b0; mcand = $urandom; mplier = $urandom; end
            if (done && done_at < 0) begin
                done_at = k;
                n_tests++; if ({hi, lo} !== 64'd42) begin n_fail++; $display("FAIL ignored_start_product got %h expected 42", {hi, lo}); end
            end
        end
        n_tests++; if (done_at != 32) begin n_fail++; $display("FAIL ignored_start_cycle got %0d expected 32", done_at); end
    endtask

    task automatic test_async_reset();
        int lat;
        int done_seen = 0;
        do_start(32'd6, 32'd7);
        wait_done(lat);
        n_tests++; if (lo !== 32'd42 || lat != 32) begin n_fail++; $display("FAIL areset_pre got lo=%0d lat=%0d expected 42/32", lo, lat); end
        do_start(32'd9, 32'd9);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        #3;
        reset = 1'b1;
        #1;
        n_tests++; if ({busy, done, hi, lo} !== 66'd0) begin n_fail++; $display("FAIL areset_immediate got %h expected 0", {busy, done, hi, lo}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL areset_no_done got %0d pulses expected 0", done_seen); end
        do_start(32'd9, 32'd9);
        wait_done(lat);
        n_tests++; if (lat != 32) begin n_fail++; $display("FAIL areset_restart_latency got %0d expected 32", lat); end
        n_tests++; if ({hi, lo} !== 64'd81) begin n_fail++; $display("FAIL areset_restart_product got %h expected 81", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int hold_bad = 0;
        int done_at  = -1;
        do_start(32'd2, 32'd3);
        wait_done(lat);
        n_tests++; if (lat != 32 || {hi, lo} !== 64'd6) begin n_fail++; $display("FAIL b2b_first got %h lat=%0d expected 6/32", {hi, lo}, lat); end
        start  = 1'b1;
        mcand  = 32'd4;
        mplier = 32'd5;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept busy/done=%b expected 10", {busy, done}); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin done_at = k; break; end
            if ({hi, lo} !== 64'd6) hold_bad++;
        end
        n_tests++; if (hold_bad != 0) begin n_fail++; $display("FAIL b2b_hold got %0d changed cycles expected 0", hold_bad); end
        n_tests++; if (done_at != 32) begin n_fail++; $display("FAIL b2b_second_latency got %0d expected 32", done_at); end
        n_tests++; if ({hi, lo} !== 64'd20) begin n_fail++; $display("FAIL b2b_second_product got %h expected 20", {hi, lo}); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: b = 32'h7FFFFFFF;
                2: a = 32'd0;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            exp = model(a, b);
            do_start(a, b);
            wait_done(lat);
            n_tests++; if (lat != 32) begin n_fail++; $display("FAIL random%0d_latency got %0d expected 32", i, lat); end
            n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL random%0d %h*%h got %h expected %h", i, a, b, {hi, lo}, exp); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        test_reset();
        test_basic();
        test_directed();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_booth.md
Name: mult_booth

Overview:
- Sequential signed multiplier for the CPU datapath: 32x32 two's-complement product, 64-bit result split into Hi (upper word) and Lo (lower word).
- Companion of the sequential divider, driving the same Hi/Lo registers used by mfhi/mflo.
- Radix-2 Booth algorithm, one step per clock. Started by a single-cycle pulse from the control unit; completion reported with a one-cycle Done pulse.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, 6, step counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high global reset
- start  input  1  single-cycle request; operands are sampled at the same edge
- Multiplicando  input  WIDTH  signed multiplicand
- Multiplicador  input  WIDTH  signed multiplier
- Busy  output  1  high while a multiplication is in progress
- Done  output  1  one-cycle pulse when Hi/Lo carry a new result
- Hi  output  WIDTH  product[2*WIDTH-1:WIDTH]
- Lo  output  WIDTH  product[WIDTH-1:0]

Behaviour:
- Reset (asynchronous, active-high, applies at any time including mid-operation):
  - State goes to IDLE.
  - Hi=0, Lo=0, Busy=0, Done=0, counter=0, accumulator=0, Q_1=0.
  - No partial result is ever written to Hi/Lo.
- States:
  - IDLE: waiting for start.
  - RUN: performing Booth steps.
  - FINISH: one cycle, Done high.
- IDLE, start=1 at an edge:
  - Latch M = sign-extended Multiplicando (WIDTH+1 bits).
  - Q = Multiplicador, A = 0 (WIDTH+1 bits), Q_1 = 0, counter = WIDTH.
  - Busy=1; go to RUN.
- RUN, every edge:
  - {Q[0],Q_1}=01: A=A+M.
  - {Q[0],Q_1}=10: A=A-M.
  - 00 or 11: no add or subtract.
  - Then arithmetic shift right of {A,Q,Q_1} by 1, with the A MSB replicated.
  - counter decrements by 1.
  - On the step where counter goes 1->0: Hi=A[WIDTH-1:0], Lo=Q (post-shift values), Done=1, Busy=0; go to FINISH.
- FINISH:
  - Done=0 at the next edge; go to IDLE.
  - start=1 in FINISH is accepted exactly as in IDLE, so back-to-back operations are allowed.
- Latency:
  - start sampled at edge 0; Booth steps run at edges 1..WIDTH.
  - Hi/Lo update and Done rises at edge WIDTH (32); Done falls at edge WIDTH+1.
  - Busy is high from edge 0 to edge WIDTH.
- start while Busy: ignored. The operation in progress and its operands are unaffected.
- Operand inputs are don't-care after the start edge.
- Hi/Lo hold the last completed result until the next completion or reset. They are not cleared at start.
- Width rule: the accumulator is WIDTH+1 bits, so -2^31 * -2^31 = +2^62 does not overflow the intermediate A-M.
- Result is exact for all operand pairs. A zero operand needs no special case and still takes the full WIDTH steps.
- Done and Busy are never high in the same cycle, except that Busy falls on the same edge at which Done rises.

Decomposition:
- Shared package (cpu_pkg) holds:
  - WIDTH constant (32), shared with the divider.
  - mult_state_t enum {IDLE, RUN, FINISH}.
  - Booth-code constants for {Q0,Q_1}.
- Sub-module mult_booth_step:
  - Purely combinational.
  - Takes A, Q, Q_1, M; returns the next A, Q, Q_1 (add/sub plus arithmetic shift).
  - Instanced once; lets the step logic be checked on its own.

Test Plan:
- 3 * 5, start pulse, then idle 40 cycles -> Done pulses exactly one cycle, 32 cycles after start; Hi=0x00000000, Lo=0x0000000F; Busy high for the cycles in between.
- 0xFFFFFFFF (-1) * 0x00000001 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF; then 0xFFFFFFFF * 0xFFFFFFFF -> Hi=0x00000000, Lo=0x00000001.
- Extremes:
  - 0x80000000 * 0x80000000 -> Hi=0x40000000, Lo=0x00000000.
  - 0x7FFFFFFF * 0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001.
  - 0x80000000 * 0x7FFFFFFF -> Hi=0xC0000000, Lo=0x80000000.
- Start 6 * 7; assert start again with 2 * 2 at cycle 10 and change the operand inputs -> second start ignored; result Hi=0, Lo=42 (0x2A) at the original Done time.
- Complete 6 * 7 (Lo=42). Start 9 * 9, then assert reset asynchronously (mid-cycle, between edges) at cycle 15 -> Busy/Done/Hi/Lo go to 0 immediately, with no Done pulse. After release, start 9 * 9 -> Lo=81 (0x51) after 32 cycles.
- Back-to-back: start 2 * 3, then start 4 * 5 in the FINISH cycle -> first Done shows Lo=6; second Done follows 32 cycles later with Lo=20; Hi/Lo keep holding 6 in between.
